// File: rtl/cm_pkg.sv
// Shared width helpers for the sorted-frame serializer and its frame buffer.
package cm_pkg;

  // Bits needed to hold a count in 0..n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  // Bits needed to index 0..n-1, never less than one.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cm_sort_ser_fb.sv
// Register-based frame FIFO; the depth need not be a power of two.
module cm_sort_ser_fb
  import cm_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned EW    = 8,
  parameter int unsigned LW    = cnt_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [EW-1:0] wr_entry,
  output logic [EW-1:0] rd_head,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  localparam int unsigned PW = idx_width(DEPTH);

  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = wr_entry;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
    // NOTE: frame storage is deliberately left out of reset; the level gates its use.
    mem_q <= mem_d;
  end

  assign rd_head = mem_q[rd_ptr_q];
  assign level   = level_q;
  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);

endmodule

// File: rtl/cm_sort_ser.sv
// Buffers sorted frames from the fixed-latency sorter and replays them word by word
// on a valid/ready stream, skipping padding and flagging frames lost to overflow.
module cm_sort_ser
  import cm_pkg::*;
#(
  parameter int unsigned DCNT   = 4,
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned FDEPTH = 2,
  parameter bit          DESC   = 1'b0,
  parameter int unsigned CWIDTH = cnt_width(DCNT)
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_vld,
  input  logic [DCNT-1:0][DWIDTH-1:0]   i_data,
  input  logic [CWIDTH-1:0]             i_cnt,
  output logic                          o_vld,
  input  logic                          i_rdy,
  output logic [DWIDTH-1:0]             o_data,
  output logic                          o_last,
  output logic [cnt_width(FDEPTH)-1:0]  o_lvl,
  output logic                          o_ovf
);

  localparam int unsigned IW = idx_width(DCNT);

  typedef struct packed {
    logic [DCNT-1:0][DWIDTH-1:0] data;
    logic [CWIDTH-1:0]           cnt;
  } entry_t;

  entry_t        wr_entry;
  entry_t        head;
  logic          full, empty;
  logic          push_req, push, pop, beat;
  logic [IW-1:0] last_idx, rd_idx;
  logic [IW-1:0] widx_q, widx_d;
  logic          ovf_q, ovf_d;

  always_comb begin
    wr_entry.data = i_data;
    wr_entry.cnt  = (i_cnt > CWIDTH'(DCNT)) ? CWIDTH'(DCNT) : i_cnt;
    push_req      = i_vld && (i_cnt != '0);

    o_vld    = !empty;
    last_idx = IW'(head.cnt - CWIDTH'(1));
    rd_idx   = DESC ? (last_idx - widx_q) : widx_q;
    o_data   = head.data[rd_idx];
    o_last   = o_vld && (widx_q == last_idx);

    beat = o_vld && i_rdy;
    pop  = beat && o_last;
    // A full buffer only accepts a frame when the head leaves in the same cycle.
    push = push_req && (!full || pop);

    widx_d = widx_q;
    if (beat) begin
      widx_d = o_last ? '0 : widx_q + IW'(1);
    end
    ovf_d = ovf_q || (push_req && full && !pop);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      widx_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      widx_q <= widx_d;
      ovf_q  <= ovf_d;
    end
  end

  assign o_ovf = ovf_q;

  cm_sort_ser_fb #(
    .DEPTH (FDEPTH),
    .EW    ($bits(entry_t))
  ) u_fb (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .push     (push),
    .pop      (pop),
    .wr_entry (wr_entry),
    .rd_head  (head),
    .level    (o_lvl),
    .full     (full),
    .empty    (empty)
  );

endmodule
